// File: rtl/ci_ctrl_pkg.sv
// Shared command encodings, FSM states and settle-timer sizing for the CI
// register sequencer (ttl191_ci_controller).
package ci_ctrl_pkg;

  localparam logic [1:0] CMD_INC  = 2'b00;
  localparam logic [1:0] CMD_DEC  = 2'b01;
  localparam logic [1:0] CMD_LOAD = 2'b10;
  localparam logic [1:0] CMD_SKIP = 2'b11;

  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_STROBE2 = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CHECK   = 3'd4
  } ci_state_t;

  // Timer reload value: SETTLE exits on the edge where the count is already zero.
  function automatic logic [SETTLE_W-1:0] settle_reload(input int cycles);
    return SETTLE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ci_settle_timer.sv
// Loadable down-counter with zero flag; times the TTL settle window after a
// strobe before the cascade Q is compared.
module ci_settle_timer
  import ci_ctrl_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ttl191_ci_controller.sv
// CI register sequencer driving a cascade of 74LS191 counters.
// Optional feature macro: CI_CTRL_SKIP_EN (CMD=11 performs a two-step skip).
//
// Handshake: a command is taken on a rising CLK edge where CMD_VALID and
// CMD_READY are both 1; CMD_READY falls on that edge and returns together
// with the DONE pulse, so the next command may be taken on the following edge.
module ttl191_ci_controller
  import ci_ctrl_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             CLR_WRAP,
  input  logic [WIDTH-1:0] CNT_Q,
  input  logic             CNT_RCO_n,
  output logic [WIDTH-1:0] CNT_D,
  output logic             CNT_LOAD_n,
  output logic             CNT_CTEN_n,
  output logic             CNT_DOWN_UP_n,
  output logic             DONE,
  output logic             ERR,
  output logic             WRAP,
  output logic [2:0]       DBG_STATE
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = settle_reload(SETTLE_CYCLES);

  ci_state_t        state;
  logic [1:0]       cmd_r;
  logic [WIDTH-1:0] exp_q;
  logic             illegal_r;
  logic             timer_load;
  logic             timer_zero;
  logic             count_cycle;

  assign DBG_STATE = state;

  // Timer is armed on the edge that moves the FSM into SETTLE.
  always_comb begin
    timer_load = 1'b0;
    if ((state == ST_STROBE) && (cmd_r != CMD_SKIP)) timer_load = 1'b1;
    if (state == ST_STROBE2)                         timer_load = 1'b1;
  end

  // A cycle in which CTEN_n is low, i.e. RCO_n is meaningful for WRAP.
  always_comb begin
    count_cycle = 1'b0;
    if ((state == ST_STROBE) && (cmd_r != CMD_LOAD)) count_cycle = 1'b1;
    if (state == ST_STROBE2)                         count_cycle = 1'b1;
  end

  ci_settle_timer u_settle (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .en       (state == ST_SETTLE),
    .zero     (timer_zero)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      cmd_r         <= CMD_INC;
      exp_q         <= '0;
      illegal_r     <= 1'b0;
      CMD_READY     <= 1'b1;
      CNT_D         <= '0;
      CNT_LOAD_n    <= 1'b1;
      CNT_CTEN_n    <= 1'b1;
      CNT_DOWN_UP_n <= 1'b0;
      DONE          <= 1'b0;
      ERR           <= 1'b0;
      WRAP          <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;

      // Clear first so a simultaneous wrap detection overrides it.
      if (CLR_WRAP) WRAP <= 1'b0;
      if (count_cycle && !CNT_RCO_n) WRAP <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            CMD_READY <= 1'b0;
            cmd_r     <= CMD;
            illegal_r <= 1'b0;
            state     <= ST_STROBE;
            case (CMD)
              CMD_INC: begin
                exp_q         <= CNT_Q + WIDTH'(1);
                CNT_CTEN_n    <= 1'b0;
                CNT_DOWN_UP_n <= 1'b0;
              end
              CMD_DEC: begin
                exp_q         <= CNT_Q - WIDTH'(1);
                CNT_CTEN_n    <= 1'b0;
                CNT_DOWN_UP_n <= 1'b1;
              end
              CMD_LOAD: begin
                exp_q      <= CMD_DATA;
                CNT_LOAD_n <= 1'b0;
                CNT_D      <= CMD_DATA;
              end
              default: begin
`ifdef CI_CTRL_SKIP_EN
                exp_q         <= CNT_Q + WIDTH'(2);
                CNT_CTEN_n    <= 1'b0;
                CNT_DOWN_UP_n <= 1'b0;
`else
                exp_q     <= CNT_Q;
                illegal_r <= 1'b1;
                state     <= ST_CHECK;
`endif
              end
            endcase
          end
        end

        ST_STROBE: begin
          if (cmd_r == CMD_SKIP) begin
            state <= ST_STROBE2;
          end else begin
            CNT_CTEN_n <= 1'b1;
            CNT_LOAD_n <= 1'b1;
            state      <= ST_SETTLE;
          end
        end

        ST_STROBE2: begin
          CNT_CTEN_n <= 1'b1;
          state      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (timer_zero) state <= ST_CHECK;
        end

        ST_CHECK: begin
          DONE      <= 1'b1;
          ERR       <= illegal_r || (CNT_Q != exp_q);
          CMD_READY <= 1'b1;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttl191_ci_controller.sv
// Directed bench for ttl191_ci_controller against a behavioural 74LS191 cascade
// (with a stuck-Q stub mode); honours CI_CTRL_SKIP_EN like the RTL.
module tb_ttl191_ci_controller;

  localparam int W = 8;
  localparam int S = 2;

  localparam logic [1:0] C_INC  = 2'b00;
  localparam logic [1:0] C_DEC  = 2'b01;
  localparam logic [1:0] C_LOAD = 2'b10;
  localparam logic [1:0] C_SKIP = 2'b11;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic         CMD_VALID = 1'b0;
  logic         CMD_READY;
  logic [1:0]   CMD = 2'b00;
  logic [W-1:0] CMD_DATA = '0;
  logic         CLR_WRAP = 1'b0;
  logic [W-1:0] CNT_Q;
  logic         CNT_RCO_n;
  logic [W-1:0] CNT_D;
  logic         CNT_LOAD_n, CNT_CTEN_n, CNT_DOWN_UP_n;
  logic         DONE, ERR, WRAP;
  logic [2:0]   DBG_STATE;

  ttl191_ci_controller #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD(CMD), .CMD_DATA(CMD_DATA), .CLR_WRAP(CLR_WRAP), .CNT_Q(CNT_Q),
    .CNT_RCO_n(CNT_RCO_n), .CNT_D(CNT_D), .CNT_LOAD_n(CNT_LOAD_n),
    .CNT_CTEN_n(CNT_CTEN_n), .CNT_DOWN_UP_n(CNT_DOWN_UP_n), .DONE(DONE),
    .ERR(ERR), .WRAP(WRAP), .DBG_STATE(DBG_STATE)
  );

  // counter cascade model; not touched by RESET
  logic [W-1:0] q_model;
  logic         stub = 1'b0;
  logic         preset_en = 1'b1;
  logic [W-1:0] preset_val = '0;

  always @(posedge CLK) begin
    if (preset_en)        q_model <= preset_val;
    else if (stub)        q_model <= q_model;
    else if (!CNT_LOAD_n) q_model <= CNT_D;
    else if (!CNT_CTEN_n) q_model <= CNT_DOWN_UP_n ? q_model - 8'd1 : q_model + 8'd1;
  end

  assign CNT_Q     = q_model;
  assign CNT_RCO_n = !(!CNT_CTEN_n && ((!CNT_DOWN_UP_n && q_model == 8'hFF) ||
                                       ( CNT_DOWN_UP_n && q_model == 8'h00)));

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver: called at a negedge with the DUT idle; returns at the DONE negedge
  task automatic do_cmd(input logic [1:0] c, input logic [W-1:0] d, input bit clr_at_strobe,
                        output int lat, output int ncten, output int nload,
                        output bit du_seen, output bit err_seen);
    lat = -1; ncten = 0; nload = 0; du_seen = 0; err_seen = 0;
    chk("ready_before_cmd", CMD_READY, 1);
    CMD = c; CMD_DATA = d; CMD_VALID = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        CMD_VALID = 1'b0;
        CMD = 2'b00;
        CMD_DATA = '0;
      end
      CLR_WRAP = clr_at_strobe && (k == 0);
      if (!CNT_CTEN_n) begin
        ncten++;
        if (CNT_DOWN_UP_n) du_seen = 1;
      end
      if (!CNT_LOAD_n) nload++;
      if (DONE) begin
        lat = k;
        err_seen = ERR;
        break;
      end
    end
    CLR_WRAP = 1'b0;
    chk("done_within_budget", (lat >= 0), 1);
  endtask

  typedef struct {
    logic [1:0]   cmd;
    logic [W-1:0] data;
    logic [W-1:0] exp_q;
    bit           exp_err;
    int           exp_lat;
    bit           exp_wrap;
    int           exp_cten;
    int           exp_load;
    bit           exp_du;
  } vec_t;

  vec_t vecs[8];

  int lat, ncten, nload, ndone;
  bit du_seen, err_seen;

  initial begin
    vecs[0] = '{C_INC,  8'h00, 8'h01, 0, 4, 0, 1, 0, 0};
    vecs[1] = '{C_LOAD, 8'hA5, 8'hA5, 0, 4, 0, 0, 1, 0};
    vecs[2] = '{C_DEC,  8'h00, 8'hA4, 0, 4, 0, 1, 0, 1};
    vecs[3] = '{C_LOAD, 8'hFF, 8'hFF, 0, 4, 0, 0, 1, 0};
    vecs[4] = '{C_INC,  8'h00, 8'h00, 0, 4, 1, 1, 0, 0};
    vecs[5] = '{C_INC,  8'h00, 8'h01, 0, 4, 1, 1, 0, 0};
    vecs[6] = '{C_LOAD, 8'h00, 8'h00, 0, 4, 1, 0, 1, 0};
    vecs[7] = '{C_DEC,  8'h00, 8'hFF, 0, 4, 1, 1, 0, 1};

    // reset state
    repeat (2) @(negedge CLK);
    preset_en = 1'b0;
    chk("rst_ready",  CMD_READY, 1);
    chk("rst_load_n", CNT_LOAD_n, 1);
    chk("rst_cten_n", CNT_CTEN_n, 1);
    chk("rst_du",     CNT_DOWN_UP_n, 0);
    chk("rst_d",      CNT_D, 8'h00);
    chk("rst_done",   DONE, 0);
    chk("rst_err",    ERR, 0);
    chk("rst_wrap",   WRAP, 0);
    chk("rst_state",  DBG_STATE, 0);
    RESET = 1'b0;
    @(negedge CLK);

    // table, issued back-to-back
    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].cmd, vecs[i].data, 0, lat, ncten, nload, du_seen, err_seen);
      chk($sformatf("v%0d_lat", i),   lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_q", i),     q_model, vecs[i].exp_q);
      chk($sformatf("v%0d_err", i),   err_seen, vecs[i].exp_err);
      chk($sformatf("v%0d_wrap", i),  WRAP, vecs[i].exp_wrap);
      chk($sformatf("v%0d_cten", i),  ncten, vecs[i].exp_cten);
      chk($sformatf("v%0d_load", i),  nload, vecs[i].exp_load);
      chk($sformatf("v%0d_du", i),    du_seen, vecs[i].exp_du);
      chk($sformatf("v%0d_ready", i), CMD_READY, 1);
      if (vecs[i].cmd == C_LOAD) chk($sformatf("v%0d_d", i), CNT_D, vecs[i].data);
    end

    // CLR_WRAP on the same edge as a new wrap: set wins
    do_cmd(C_LOAD, 8'hFF, 0, lat, ncten, nload, du_seen, err_seen);
    do_cmd(C_INC, 8'h00, 1, lat, ncten, nload, du_seen, err_seen);
    chk("clr_vs_set_q", q_model, 8'h00);
    chk("clr_vs_set_wrap", WRAP, 1);
    CLR_WRAP = 1'b1;
    @(negedge CLK);
    CLR_WRAP = 1'b0;
    chk("clr_alone_wrap", WRAP, 0);

    // stuck counter -> ERR with DONE
    preset_val = 8'h10; preset_en = 1'b1;
    @(negedge CLK);
    preset_en = 1'b0; stub = 1'b1;
    do_cmd(C_INC, 8'h00, 0, lat, ncten, nload, du_seen, err_seen);
    chk("stub_lat", lat, 4);
    chk("stub_err", err_seen, 1);
    chk("stub_q", q_model, 8'h10);
    chk("stub_ready", CMD_READY, 1);
    @(negedge CLK);
    chk("stub_err_pulse", ERR, 0);
    stub = 1'b0;

    // CMD=11
    do_cmd(C_LOAD, 8'h1E, 0, lat, ncten, nload, du_seen, err_seen);
    do_cmd(C_SKIP, 8'h00, 0, lat, ncten, nload, du_seen, err_seen);
`ifdef CI_CTRL_SKIP_EN
    chk("skip_lat", lat, 5);
    chk("skip_cten", ncten, 2);
    chk("skip_q", q_model, 8'h20);
    chk("skip_err", err_seen, 0);
`else
    chk("illegal_lat", lat, 1);
    chk("illegal_cten", ncten, 0);
    chk("illegal_load", nload, 0);
    chk("illegal_q", q_model, 8'h1E);
    chk("illegal_err", err_seen, 1);
`endif

    // reset during SETTLE of a load
    CMD = C_LOAD; CMD_DATA = 8'h3C; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    chk("abort_in_settle", DBG_STATE, 3);
    RESET = 1'b1;
    #1;
    chk("abort_ready", CMD_READY, 1);
    chk("abort_done", DONE, 0);
    chk("abort_load_n", CNT_LOAD_n, 1);
    chk("abort_cten_n", CNT_CTEN_n, 1);
    chk("abort_state", DBG_STATE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_q_kept", q_model, 8'h3C);
    do_cmd(C_INC, 8'h00, 0, lat, ncten, nload, du_seen, err_seen);
    chk("post_abort_lat", lat, 4);
    chk("post_abort_q", q_model, 8'h3D);
    chk("post_abort_err", err_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
